exp_taylor_sequencer: RTL

// - Controller that evaluates e^x for IEEE-754 single precision as a truncated Taylor series.
// - Sequences one shared fixed-latency FP multiplier and one FP adder. Both are external; this block holds no FP arithmetic.
// - Iteration: term_k = term_{k-1} * x * (1/k), sum += term_k. The 1/k constants come from an internal ROM.
// - Sits between the request source (valid/ready) and the shared fp_mul/fp_add datapath.

---
 rtl/exp_taylor_sequencer_if.sv | 31 +++
 rtl/exp_taylor_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/exp_taylor_sequencer_if.sv
// Bundle of request/result handshake and shared FP datapath signals for exp_taylor_sequencer.
// slave = sequencer side; master = environment (request source, consumer, fp_mul/fp_add).
interface exp_taylor_sequencer_if;
   logic        start_valid;
   logic        start_ready;
   logic [31:0] x_in;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_out;
   logic        busy;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_go;
   logic [31:0] mul_p;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_go;
   logic [31:0] add_s;

   modport slave (
      input  start_valid, x_in, res_ready, mul_p, add_s,
      output start_ready, res_valid, res_out, busy,
             mul_a, mul_b, mul_go, add_a, add_b, add_go
   );

   modport master (
      output start_valid, x_in, res_ready, mul_p, add_s,
      input  start_ready, res_valid, res_out, busy,
             mul_a, mul_b, mul_go, add_a, add_b, add_go
   );
endinterface

// File: rtl/exp_taylor_sequencer.sv
// Sequences an external FP multiplier/adder to evaluate e^x as a truncated Taylor series.
// Optional: define EXP_SPECIAL_BYPASS_EN to short-circuit x=+/-0 and NaN at accept.
module exp_taylor_sequencer #(
   parameter int NUM_TERMS = 8,
   parameter int MUL_LAT   = 3,
   parameter int ADD_LAT   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   exp_taylor_sequencer_if.slave bus
);
   localparam logic [31:0] ONE  = 32'h3F80_0000;
   localparam int          LMAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
   localparam int          CW   = $clog2(LMAX + 1);
   localparam logic [4:0]  K_LAST = 5'(NUM_TERMS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_MX, S_WMX, S_MR, S_WMR, S_AD, S_WAD, S_DONE
   } state_t;

   state_t        state_q;
   logic [31:0]   x_q, sum_q, term_q, res_out_q;
   logic [31:0]   mul_a_q, mul_b_q, add_a_q, add_b_q;
   logic          mul_go_q, add_go_q, res_valid_q;
   logic [4:0]    k_q;
   logic [CW-1:0] cnt_q;

   // 1/k rounded to nearest single precision.
   function automatic logic [31:0] rom_recip(input logic [4:0] k);
      case (k)
         5'd1:    rom_recip = 32'h3F80_0000;
         5'd2:    rom_recip = 32'h3F00_0000;
         5'd3:    rom_recip = 32'h3EAA_AAAB;
         5'd4:    rom_recip = 32'h3E80_0000;
         5'd5:    rom_recip = 32'h3E4C_CCCD;
         5'd6:    rom_recip = 32'h3E2A_AAAB;
         5'd7:    rom_recip = 32'h3E12_4925;
         5'd8:    rom_recip = 32'h3E00_0000;
         5'd9:    rom_recip = 32'h3DE3_8E39;
         5'd10:   rom_recip = 32'h3DCC_CCCD;
         5'd11:   rom_recip = 32'h3DBA_2E8C;
         5'd12:   rom_recip = 32'h3DAA_AAAB;
         5'd13:   rom_recip = 32'h3D9D_89D9;
         5'd14:   rom_recip = 32'h3D92_4925;
         5'd15:   rom_recip = 32'h3D88_8889;
         default: rom_recip = 32'h0000_0000;
      endcase
   endfunction

`ifdef EXP_SPECIAL_BYPASS_EN
   logic x_zero, x_nan;
   assign x_zero = (bus.x_in[30:0] == 31'd0);
   assign x_nan  = (bus.x_in[30:23] == 8'hFF) && (bus.x_in[22:0] != 23'd0);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         sum_q       <= '0;
         term_q      <= '0;
         k_q         <= 5'd1;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_out_q   <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_go_q    <= 1'b0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_go_q    <= 1'b0;
      end else begin
         // Issue registers are one-cycle: set only on the transition into an issue state.
         mul_go_q <= 1'b0;
         add_go_q <= 1'b0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         add_a_q  <= '0;
         add_b_q  <= '0;
         unique case (state_q)
            S_IDLE: if (bus.start_valid) begin
               x_q    <= bus.x_in;
               sum_q  <= ONE;
               term_q <= ONE;
               k_q    <= 5'd1;
`ifdef EXP_SPECIAL_BYPASS_EN
               if (x_zero || x_nan) begin
                  res_valid_q <= 1'b1;
                  res_out_q   <= x_zero ? ONE : (bus.x_in | 32'h0040_0000);
                  state_q     <= S_DONE;
               end else begin
                  mul_a_q  <= ONE;
                  mul_b_q  <= bus.x_in;
                  mul_go_q <= 1'b1;
                  state_q  <= S_MX;
               end
`else
               mul_a_q  <= ONE;
               mul_b_q  <= bus.x_in;
               mul_go_q <= 1'b1;
               state_q  <= S_MX;
`endif
            end
            S_MX: begin
               cnt_q   <= CW'(MUL_LAT - 1);
               state_q <= S_WMX;
            end
            S_WMX: if (cnt_q == '0) begin
               term_q   <= bus.mul_p;
               mul_a_q  <= bus.mul_p;
               mul_b_q  <= rom_recip(k_q);
               mul_go_q <= 1'b1;
               state_q  <= S_MR;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            S_MR: begin
               cnt_q   <= CW'(MUL_LAT - 1);
               state_q <= S_WMR;
            end
            S_WMR: if (cnt_q == '0) begin
               term_q   <= bus.mul_p;
               add_a_q  <= sum_q;
               add_b_q  <= bus.mul_p;
               add_go_q <= 1'b1;
               state_q  <= S_AD;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            S_AD: begin
               cnt_q   <= CW'(ADD_LAT - 1);
               state_q <= S_WAD;
            end
            S_WAD: if (cnt_q == '0) begin
               sum_q <= bus.add_s;
               if (k_q == K_LAST) begin
                  res_valid_q <= 1'b1;
                  res_out_q   <= bus.add_s;
                  state_q     <= S_DONE;
               end else begin
                  k_q      <= k_q + 5'd1;
                  mul_a_q  <= term_q;
                  mul_b_q  <= x_q;
                  mul_go_q <= 1'b1;
                  state_q  <= S_MX;
               end
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            S_DONE: if (bus.res_ready) begin
               res_valid_q <= 1'b0;
               res_out_q   <= '0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.start_ready = (state_q == S_IDLE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.res_valid   = res_valid_q;
   assign bus.res_out     = res_out_q;
   assign bus.mul_a       = mul_a_q;
   assign bus.mul_b       = mul_b_q;
   assign bus.mul_go      = mul_go_q;
   assign bus.add_a       = add_a_q;
   assign bus.add_b       = add_b_q;
   assign bus.add_go      = add_go_q;
endmodule
